// File: rtl/spu_frame_loader.sv
// -----------------------------------------------------------------------------
// spu_frame_loader
//
// Byte-serial front end for the TinySPU datapath. Three bytes form one command
// frame:
//   byte0 = {A, B}, byte1 = {C, D}, byte2 = {Op, ignored nibble}
// On acceptance of byte2 all operands and the opcode are loaded on the same
// edge. The loader then waits SPU_LATENCY+1 edges, captures {spu_M, spu_N}
// into res_data and holds it under a valid/ready handshake.
//
// Optional feature (compile-time macro SPU_LOADER_TIMEOUT_EN):
//   An idle counter aborts a partial frame (GET1/GET2) after TIMEOUT
//   consecutive cycles without in_valid and pulses frame_err for one cycle.
//   Without the macro a partial frame waits forever and frame_err is 0.
//
// Parameters:
//   SPU_LATENCY  edges from operand update until spu_M/spu_N are valid
//   TIMEOUT      idle-cycle limit inside a partial frame (timeout build only)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    frame byte and its valid strobe
//   in_ready            loader can accept a byte (decoded from state)
//   A, B, C, D, Op      operands and opcode driven to the SPU
//   spu_M, spu_N        SPU result nibbles
//   res_data/res_valid  captured result {spu_M, spu_N} and its valid flag
//   res_ready           consumer accepts res_data
//   frame_err           one-cycle pulse when a partial frame is discarded
// -----------------------------------------------------------------------------
module spu_frame_loader #(
  parameter int SPU_LATENCY = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] Op,
  input  logic [3:0] spu_M,
  input  logic [3:0] spu_N,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       frame_err
);

  // Wait counter must be able to hold the value SPU_LATENCY.
  localparam int CNT_W = (SPU_LATENCY < 1) ? 1 : $clog2(SPU_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(SPU_LATENCY);

  if (TIMEOUT < 1 || SPU_LATENCY < 0) begin : g_bad_param
    $error("spu_frame_loader: TIMEOUT must be >= 1 and SPU_LATENCY >= 0");
  end

  typedef enum logic [2:0] {
    S_GET0,
    S_GET1,
    S_GET2,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      stage_q, stage_d;     // {byte0, byte1}
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       c_q, c_d;
  logic [3:0]       d_q, d_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

`ifdef SPU_LOADER_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Abort happens on the edge that would make the idle count equal TIMEOUT.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              frame_err_q, frame_err_d;
`endif

  // in_ready is a pure state decode, independent of in_valid.
  assign in_ready = (state_q == S_GET0) || (state_q == S_GET1) ||
                    (state_q == S_GET2);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    stage_d     = stage_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    op_d        = op_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_GET0: begin
        if (accept) begin
          stage_d[15:8] = in_data;
          state_d       = S_GET1;
        end
      end

      S_GET1: begin
        if (accept) begin
          stage_d[7:0] = in_data;
          state_d      = S_GET2;
        end
      end

      S_GET2: begin
        // All operands and the opcode move together so the SPU never sees a
        // mixture of two frames.
        if (accept) begin
          a_d     = stage_q[15:12];
          b_d     = stage_q[11:8];
          c_d     = stage_q[7:4];
          d_d     = stage_q[3:0];
          op_d    = in_data[7:4];
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == LAT_CNT) begin
          res_d       = {spu_M, spu_N};
          res_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_GET0;
        end
      end

      default: begin
        state_d = S_GET0;
      end
    endcase

`ifdef SPU_LOADER_TIMEOUT_EN
    idle_d      = '0;
    frame_err_d = 1'b0;
    if ((state_q == S_GET1 || state_q == S_GET2) && !in_valid) begin
      if (idle_q == IDLE_LAST) begin
        // Discard the partial frame; operands keep the last full frame.
        stage_d     = '0;
        state_d     = S_GET0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and result registers are reset too, not only the
      // control state, because they drive outputs that must read 0 in reset.
      state_q     <= S_GET0;
      stage_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      stage_q     <= stage_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      op_q        <= op_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SPU_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign D         = d_q;
  assign Op        = op_q;
  assign res_data  = res_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_spu_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_spu_frame_loader
//
// Drives command frames into spu_frame_loader, models the SPU as a 2-cycle
// registered XOR unit (M = A^C, N = B^D) and compares the loader outputs with
// a frame-level reference: operands come straight from the byte fields and
// the expected result byte is byte0 ^ byte1.
// -----------------------------------------------------------------------------
module tb_spu_frame_loader;

  localparam int LAT = 2;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] A, B, C, D, Op;
  logic [3:0] spu_M, spu_N;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       frame_err;

  spu_frame_loader #(
    .SPU_LATENCY(LAT),
    .TIMEOUT    (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .Op       (Op),
    .spu_M    (spu_M),
    .spu_N    (spu_N),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // SPU stand-in: two register stages between operands and M/N.
  logic [7:0] spu_s1 = 8'h00;
  logic [7:0] spu_s2 = 8'h00;
  always @(posedge clk) begin
    spu_s1 <= {A ^ C, B ^ D};
    spu_s2 <= spu_s1;
  end
  assign spu_M = spu_s2[7:4];
  assign spu_N = spu_s2[3:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ferr_cnt = 0;
  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

  int total = 0;
  int bad   = 0;

  // Reference operand state: what A..D/Op must show right now.
  logic [3:0] m_a = 4'h0, m_b = 4'h0, m_c = 4'h0, m_d = 4'h0, m_op = 4'h0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ops(input string tag);
    check(tag, {12'h0, A, B, C, D, Op}, {12'h0, m_a, m_b, m_c, m_d, m_op});
  endtask

  // Offer one byte after `gap` idle cycles and wait until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
  endtask

  // Send a full frame; operands must only move on the byte2 edge.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int g0, input int g1,
                            input int g2);
    send_byte(b0, g0);
    check_ops("ops_after_b0");
    send_byte(b1, g1);
    check_ops("ops_after_b1");
    send_byte(b2, g2);
    m_a  = b0[7:4];
    m_b  = b0[3:0];
    m_c  = b1[7:4];
    m_d  = b1[3:0];
    m_op = b2[7:4];
    check_ops("ops_after_b2");
    check("valid_at_load", {31'h0, res_valid}, 32'h0);
  endtask

  // Called right after the byte2 edge: latency, result, hold, handshake.
  task automatic finish_frame(input logic [7:0] exp_res, input int hold,
                              input bit junk);
    int k;
    k = 0;
    while (!res_valid && k < 20) begin
      res_ready = 1'($urandom);   // outside HOLD this must not matter
      step();
      k++;
    end
    check("latency", k, LAT + 1);
    check("res_data", {24'h0, res_data}, {24'h0, exp_res});
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        in_data  = 8'h11;
        in_valid = 1'b1;
      end
      step();
      check("hold_valid", {31'h0, res_valid}, 32'h1);
      check("hold_data", {24'h0, res_data}, {24'h0, exp_res});
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    check("hs_valid_low", {31'h0, res_valid}, 32'h0);
    check("hs_in_ready", {31'h0, in_ready}, 32'h1);
    check_ops("ops_after_hs");
  endtask

  initial begin
    int c0;
    int f0;
    bit seen;
    logic [7:0] r0, r1, r2;
    int g0, g1, g2, hd;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {7'h0, A, B, C, D, Op, res_data, res_valid, frame_err},
          32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic frame, back-to-back, including frame period
    res_ready = 1'b1;
    c0 = cyc;
    send_frame(8'h5A, 8'h3C, 8'h70, 0, 0, 0);
    check("basic_ops", {12'h0, A, B, C, D, Op}, 32'h5A3C7);
    finish_frame(8'h66, 0, 1'b0);
    check("period", cyc - c0, 3 + LAT + 2);

    // Backpressure with an ignored byte offered during HOLD
    send_frame(8'h5A, 8'h3C, 8'h70, 0, 0, 0);
    finish_frame(8'h66, 10, 1'b1);

    // Gapped input (in_valid toggling); also shows 0x11 was not consumed
    send_frame(8'h5A, 8'h3C, 8'h70, 1, 1, 1);
    finish_frame(8'h66, 0, 1'b0);

    // Ignored low nibble of byte2
    send_frame(8'h5A, 8'h3C, 8'h7F, 0, 0, 0);
    check("nibble_op", {28'h0, Op}, 32'h7);
    finish_frame(8'h66, 1, 1'b0);

    // Reset one cycle after byte2
    send_frame(8'hC3, 8'h81, 8'h20, 0, 0, 0);
    step();
    rst_n = 1'b0;
    #1;
    check("midwait_rst_outs",
          {7'h0, A, B, C, D, Op, res_data, res_valid, frame_err}, 32'h0);
    check("midwait_rst_in_ready", {31'h0, in_ready}, 32'h1);
    m_a = 4'h0; m_b = 4'h0; m_c = 4'h0; m_d = 4'h0; m_op = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | res_valid;
    end
    check("no_res_after_rst", {31'h0, seen}, 32'h0);
    check("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

`ifdef SPU_LOADER_TIMEOUT_EN
    // Partial frame abandoned after TMO idle cycles
    f0 = ferr_cnt;
    send_byte(8'h5A, 0);
    repeat (TMO - 1) step();
    check("ferr_early", {31'h0, frame_err}, 32'h0);
    step();
    check("ferr_pulse", {31'h0, frame_err}, 32'h1);
    check("ferr_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check("ferr_once", {31'h0, frame_err}, 32'h0);
    check("ferr_count", ferr_cnt - f0, 1);
    check_ops("ops_after_timeout");
    send_frame(8'h12, 8'h34, 8'hF0, 0, 0, 0);
    finish_frame(8'h26, 0, 1'b0);
`else
    // Without the timeout, a long gap inside a frame is harmless
    f0 = ferr_cnt;
    send_frame(8'h12, 8'h34, 8'hF0, 0, TMO + 5, TMO + 5);
    finish_frame(8'h26, 0, 1'b0);
    check("no_ferr", ferr_cnt - f0, 0);
`endif

    // Randomized frames
    f0 = ferr_cnt;
    for (int n = 0; n < 40; n++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      g0 = int'($urandom_range(3, 0));
      g1 = int'($urandom_range(3, 0));
      g2 = int'($urandom_range(3, 0));
      hd = int'($urandom_range(4, 0));
      c0 = cyc;
      send_frame(r0, r1, r2, g0, g1, g2);
      finish_frame(r0 ^ r1, hd, 1'($urandom));
      if (g0 == 0 && g1 == 0 && g2 == 0 && hd == 0)
        check("rand_period", cyc - c0, 3 + LAT + 2);
    end
    check("rand_no_ferr", ferr_cnt - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

endmodule
